ahblite_pid_regs: RTL and testbench
===================================

Name: ahblite_pid_regs

Overview:
AHB-Lite slave (responder) giving the bus master register access to the PID accelerator core. Attaches to one peripheral port of the AHB-Lite interconnect (HSEL/HREADY in, HREADYOUT/HRESP/HRDATA out). Holds coefficient, setpoint and feedback registers. Generates a start/clear pulse to the PID core and latches its result. Supports configurable read wait states and the two-cycle AHB ERROR response.

Parameters:
DATA_W, 16, width of coefficient/operand/result registers (1..32); zero-extended on read, low DATA_W bits taken on write
RD_WAIT, 1, wait states inserted on every read data phase (0..3)

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slave select from interconnect decoder
HADDR  in  32  address; only HADDR[5:2] decoded
HTRANS  in  2  transfer type; HTRANS[1]=1 means NONSEQ/SEQ
HSIZE  in  3  transfer size
HWRITE  in  1  1=write
HWDATA  in  32  write data (data phase)
HREADY  in  1  bus-wide ready from interconnect
HREADYOUT  out  1  this slave's ready
HRESP  out  1  0=OKAY 1=ERROR
HRDATA  out  32  read data
pid_start  out  1  one-cycle start pulse to PID core
pid_clr  out  1  one-cycle accumulator-clear pulse
pid_kp, pid_ki, pid_kd, pid_sp, pid_fb  out  DATA_W each  register contents
pid_busy  in  1  core computing
pid_done  in  1  one-cycle completion pulse
pid_result  in  DATA_W  core output, valid with pid_done
irq  out  1  DONE & IRQ_EN

Behaviour:
- Reset (asynchronous, HRESETn=0): HREADYOUT=1, HRESP=0, HRDATA=0, pid_start=0, pid_clr=0, irq=0, all registers 0, FSM=IDLE.
- Register map (offset): 0x00 CTRL (bit0 START W1-pulse, reads 0; bit1 IRQ_EN RW; bit2 CLR W1-pulse, reads 0). 0x04 STATUS (bit0 BUSY=pid_busy RO; bit1 DONE sticky, W1C). 0x08 KP. 0x0C KI. 0x10 KD. 0x14 SP. 0x18 FB (all RW). 0x1C RESULT (RO, loaded on pid_done). 0x20-0x3C unmapped.
- Address phase is accepted when HSEL & HTRANS[1] & HREADY. Captured fields: offset, HWRITE, error class. Otherwise the slave returns to or stays in IDLE with HREADYOUT=1, HRESP=0.
- Error class: HSIZE!=3'b010, or unmapped offset, or a write to KP..FB while pid_busy=1 at the address phase. The register is left unchanged.
- FSM states: IDLE, WR, RWAIT, RD, ERR1, ERR2.
  - IDLE: accept write -> WR; accept read -> RWAIT if RD_WAIT>0, else RD; accept error -> ERR1.
  - WR: HREADYOUT=1. HWDATA is committed at the end of this cycle. Next state follows the IDLE accept rules, so back-to-back transfers incur no bubble.
  - RWAIT: HREADYOUT=0 for RD_WAIT cycles (counter), then -> RD.
  - RD: HREADYOUT=1. HRDATA = register value sampled on entry to RD. Next state follows the IDLE accept rules.
  - ERR1: HREADYOUT=0, HRESP=1, then -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Next state follows the IDLE accept rules.
- HRDATA=0 in every state except RD.
- Writes to RO registers (STATUS bit0, RESULT): ignored, OKAY response.
- pid_start is asserted the cycle after the WR commit when START=1 and pid_busy=0. START while busy is ignored (OKAY). pid_clr follows the same timing with no busy check.
- Writing START and CLR together produces both pulses in the same cycle.
- DONE: set by pid_done. If pid_done coincides with a W1C write in the same cycle, set wins.
- RESULT is loaded on pid_done regardless of any bus activity.
- irq is registered: it follows DONE&IRQ_EN one cycle later.

Test Plan:
- Reset: hold HRESETn=0 mid-read (state RWAIT) -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately; KP reads back 0 after release.
- Write KP=0x1234, then read KP with RD_WAIT=1 -> write zero-wait; read shows exactly one HREADYOUT=0 cycle, then HRDATA=0x00001234, HRESP=0.
- Write CTRL=0x3 with pid_busy=0 -> pid_start high for exactly one cycle, IRQ_EN=1. Then pulse pid_done with pid_result=0x00AB -> RESULT=0x00AB, STATUS=0x2, irq=1 one cycle later. Write STATUS=0x2 -> DONE=0, irq=0.
- Read offset 0x24, then a halfword write (HSIZE=1) to KP -> each gives HREADYOUT=0/HRESP=1 followed by HREADYOUT=1/HRESP=1; KP unchanged.
- pid_busy=1, write KD=0x55 -> two-cycle ERROR, KD unchanged. Write START while busy -> OKAY, no pid_start pulse.
- Back-to-back write SP=7 followed by read SP with HREADY held low one cycle by another slave -> address phase not accepted until HREADY=1; read returns 0x00000007.

Source files
------------

// File: rtl/ahblite_pid_regs_if.sv
// AHB-Lite peripheral port bundle between the interconnect and the PID register slave.
// Pure wiring: no storage, zero latency.
// HREADY comes from the interconnect; HREADYOUT is this slave's stall request.
interface ahblite_pid_regs_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahblite_pid_regs.sv
// AHB-Lite register slave for the PID core: coefficients, setpoint, feedback, control, status, result.
// Writes zero-wait; reads take RD_WAIT wait states; errors use the two-cycle ERROR response.
// Stalls the bus only via HREADYOUT (RWAIT, ERR1); address phases are taken only when HREADY=1.
module ahblite_pid_regs #(
    parameter int DATA_W  = 16,
    parameter int RD_WAIT = 1
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    ahblite_pid_regs_if.slave bus,
    output logic              pid_start,
    output logic              pid_clr,
    output logic [DATA_W-1:0] pid_kp,
    output logic [DATA_W-1:0] pid_ki,
    output logic [DATA_W-1:0] pid_kd,
    output logic [DATA_W-1:0] pid_sp,
    output logic [DATA_W-1:0] pid_fb,
    input  logic              pid_busy,
    input  logic              pid_done,
    input  logic [DATA_W-1:0] pid_result,
    output logic              irq
);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RWAIT, S_RD, S_ERR1, S_ERR2} state_t;

    state_t            state_q, state_d, acc_state;
    logic [3:0]        addr_q, addr_d;
    logic [1:0]        wcnt_q, wcnt_d;
    logic [31:0]       hrdata_q, hrdata_d;
    logic              start_q, start_d, clr_q, clr_d, irq_q, irq_d;
    logic              irq_en_q, irq_en_d, done_q, done_d;
    logic [DATA_W-1:0] kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
    logic [DATA_W-1:0] sp_q, sp_d, fb_q, fb_d, result_q, result_d;

    logic        accept, a_err;
    logic [3:0]  a_off, rd_off;
    logic [31:0] rd_val;
    logic        unused_bits;

    // Address-phase decode and the state an accepted (or absent) transfer leads to
    always_comb begin
        accept = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
        a_off  = bus.HADDR[5:2];
        a_err  = (bus.HSIZE != 3'b010) | a_off[3]
               | (bus.HWRITE & pid_busy & (a_off >= 4'd2) & (a_off <= 4'd6));
        if (!accept)           acc_state = S_IDLE;
        else if (a_err)        acc_state = S_ERR1;
        else if (bus.HWRITE)   acc_state = S_WR;
        else if (RD_WAIT > 0)  acc_state = S_RWAIT;
        else                   acc_state = S_RD;
    end

    // Next-state logic; every state with HREADYOUT=1 can take a new address phase
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE, S_WR, S_RD, S_ERR2: begin
                state_d = acc_state;
                wcnt_d  = 2'(RD_WAIT - 1);
                if (accept) addr_d = a_off;
            end
            S_RWAIT: begin
                if (wcnt_q == 2'd0) state_d = S_RD;
                else                wcnt_d  = wcnt_q - 2'd1;
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    // Register file update: bus commit in WR, then pid_done so that DONE set beats W1C
    always_comb begin
        kp_d     = kp_q;
        ki_d     = ki_q;
        kd_d     = kd_q;
        sp_d     = sp_q;
        fb_d     = fb_q;
        irq_en_d = irq_en_q;
        done_d   = done_q;
        result_d = result_q;
        start_d  = 1'b0;
        clr_d    = 1'b0;
        if (state_q == S_WR) begin
            case (addr_q)
                4'h0: begin
                    irq_en_d = bus.HWDATA[1];
                    start_d  = bus.HWDATA[0] & ~pid_busy;
                    clr_d    = bus.HWDATA[2];
                end
                4'h1: if (bus.HWDATA[1]) done_d = 1'b0;
                4'h2: kp_d = bus.HWDATA[DATA_W-1:0];
                4'h3: ki_d = bus.HWDATA[DATA_W-1:0];
                4'h4: kd_d = bus.HWDATA[DATA_W-1:0];
                4'h5: sp_d = bus.HWDATA[DATA_W-1:0];
                4'h6: fb_d = bus.HWDATA[DATA_W-1:0];
                default: ;
            endcase
        end
        if (pid_done) begin
            done_d   = 1'b1;
            result_d = pid_result;
        end
        irq_d = done_q & irq_en_q;
    end

    // Read data is sampled on entry to RD from next-state values, so a read right behind a write sees it
    always_comb begin
        rd_off = (state_q == S_RWAIT) ? addr_q : a_off;
        case (rd_off)
            4'h0:    rd_val = {29'd0, 1'b0, irq_en_d, 1'b0};
            4'h1:    rd_val = {30'd0, done_d, pid_busy};
            4'h2:    rd_val = 32'(kp_d);
            4'h3:    rd_val = 32'(ki_d);
            4'h4:    rd_val = 32'(kd_d);
            4'h5:    rd_val = 32'(sp_d);
            4'h6:    rd_val = 32'(fb_d);
            4'h7:    rd_val = 32'(result_d);
            default: rd_val = 32'd0;
        endcase
        hrdata_d = (state_d == S_RD) ? rd_val : 32'd0;
    end

    // State and register storage
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wcnt_q   <= '0;
            hrdata_q <= '0;
            start_q  <= 1'b0;
            clr_q    <= 1'b0;
            irq_q    <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            kp_q     <= '0;
            ki_q     <= '0;
            kd_q     <= '0;
            sp_q     <= '0;
            fb_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wcnt_q   <= wcnt_d;
            hrdata_q <= hrdata_d;
            start_q  <= start_d;
            clr_q    <= clr_d;
            irq_q    <= irq_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            kp_q     <= kp_d;
            ki_q     <= ki_d;
            kd_q     <= kd_d;
            sp_q     <= sp_d;
            fb_q     <= fb_d;
            result_q <= result_d;
        end
    end

    assign bus.HREADYOUT = !((state_q == S_RWAIT) || (state_q == S_ERR1));
    assign bus.HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign bus.HRDATA    = hrdata_q;

    assign pid_start = start_q;
    assign pid_clr   = clr_q;
    assign irq       = irq_q;
    assign pid_kp    = kp_q;
    assign pid_ki    = ki_q;
    assign pid_kd    = kd_q;
    assign pid_sp    = sp_q;
    assign pid_fb    = fb_q;

    // Address bits outside the decoded window and HTRANS[0] carry no meaning here
    assign unused_bits = ^{bus.HADDR[31:6], bus.HADDR[1:0], bus.HTRANS[0], bus.HWDATA};

endmodule

// File: tb/tb_ahblite_pid_regs.sv
// Directed bench for the AHB-Lite PID register slave (DATA_W=16, RD_WAIT=1).
// Transfers run as single address/data phases; HREADY can be held low to mimic another slave.
// Expected values are hand-computed constants.
module tb_ahblite_pid_regs;

    logic        hclk;
    logic        hresetn;
    logic        hready_en;
    logic        pid_start, pid_clr, irq;
    logic [15:0] pid_kp, pid_ki, pid_kd, pid_sp, pid_fb;
    logic        pid_busy, pid_done;
    logic [15:0] pid_result;

    int n_chk  = 0;
    int n_fail = 0;

    ahblite_pid_regs_if bus ();

    assign bus.HREADY = bus.HREADYOUT & hready_en;

    ahblite_pid_regs #(.DATA_W(16), .RD_WAIT(1)) dut (
        .HCLK       (hclk),
        .HRESETn    (hresetn),
        .bus        (bus),
        .pid_start  (pid_start),
        .pid_clr    (pid_clr),
        .pid_kp     (pid_kp),
        .pid_ki     (pid_ki),
        .pid_kd     (pid_kd),
        .pid_sp     (pid_sp),
        .pid_fb     (pid_fb),
        .pid_busy   (pid_busy),
        .pid_done   (pid_done),
        .pid_result (pid_result),
        .irq        (irq)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One complete transfer; returns final-cycle read data/HRESP, wait count and first-cycle HRESP
    task automatic ahb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [2:0] size, output logic [31:0] rdata,
                            output int nwait, output logic resp0, output logic resp);
        int n;
        @(posedge hclk); #1;
        bus.HSEL   = 1'b1;
        bus.HADDR  = addr;
        bus.HTRANS = 2'b10;
        bus.HWRITE = wr;
        bus.HSIZE  = size;
        n = 0;
        while (!bus.HREADY && n < 20) begin
            @(posedge hclk); #1;
            n++;
        end
        if (n >= 20) chk("addr_phase_timeout", 32'(n), 32'd0);
        @(posedge hclk); #1;
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWDATA = wdata;
        resp0 = bus.HRESP;
        nwait = 0;
        while (!bus.HREADYOUT && nwait < 20) begin
            @(posedge hclk); #1;
            nwait++;
        end
        if (nwait >= 20) chk("data_phase_timeout", 32'(nwait), 32'd0);
        rdata = bus.HRDATA;
        resp  = bus.HRESP;
    endtask

    initial begin
        logic [31:0] rd;
        int          nw;
        logic        r0, r1;
        logic        seen;

        hresetn    = 1'b0;
        hready_en  = 1'b1;
        pid_busy   = 1'b0;
        pid_done   = 1'b0;
        pid_result = 16'h0;
        bus.HSEL   = 1'b0;
        bus.HADDR  = 32'h0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = 3'b010;
        bus.HWDATA = 32'h0;

        #3;
        chk("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        chk("rst_hresp", 32'(bus.HRESP), 32'd0);
        chk("rst_hrdata", bus.HRDATA, 32'h0);
        chk("rst_start_clr_irq", {29'd0, pid_start, pid_clr, irq}, 32'd0);
        repeat (2) @(posedge hclk);
        #1 hresetn = 1'b1;

        // Zero-wait write, one-wait read
        ahb_xfer(1'b1, 32'h08, 32'h0000_1234, 3'b010, rd, nw, r0, r1);
        chk("kp_wr_wait", 32'(nw), 32'd0);
        chk("kp_wr_resp", 32'(r1), 32'd0);
        ahb_xfer(1'b0, 32'h08, 32'h0, 3'b010, rd, nw, r0, r1);
        chk("kp_rd_wait", 32'(nw), 32'd1);
        chk("kp_rd_data", rd, 32'h0000_1234);
        chk("kp_rd_resp", 32'(r1), 32'd0);
        chk("kp_port", 32'(pid_kp), 32'h0000_1234);

        // START + IRQ_EN
        ahb_xfer(1'b1, 32'h00, 32'h3, 3'b010, rd, nw, r0, r1);
        @(posedge hclk); #1;
        chk("start_pulse_hi", 32'(pid_start), 32'd1);
        chk("clr_quiet", 32'(pid_clr), 32'd0);
        @(posedge hclk); #1;
        chk("start_pulse_lo", 32'(pid_start), 32'd0);
        ahb_xfer(1'b0, 32'h00, 32'h0, 3'b010, rd, nw, r0, r1);
        chk("ctrl_rd", rd, 32'h2);

        // Completion: RESULT, sticky DONE, delayed irq
        @(posedge hclk); #1;
        pid_done   = 1'b1;
        pid_result = 16'h00AB;
        @(posedge hclk); #1;
        pid_done   = 1'b0;
        pid_result = 16'h0;
        chk("irq_not_yet", 32'(irq), 32'd0);
        @(posedge hclk); #1;
        chk("irq_set", 32'(irq), 32'd1);
        ahb_xfer(1'b0, 32'h1C, 32'h0, 3'b010, rd, nw, r0, r1);
        chk("result_rd", rd, 32'h0000_00AB);
        ahb_xfer(1'b0, 32'h04, 32'h0, 3'b010, rd, nw, r0, r1);
        chk("status_done", rd, 32'h2);
        ahb_xfer(1'b1, 32'h04, 32'h2, 3'b010, rd, nw, r0, r1);
        @(posedge hclk); #1;
        @(posedge hclk); #1;
        chk("irq_cleared", 32'(irq), 32'd0);
        ahb_xfer(1'b0, 32'h04, 32'h0, 3'b010, rd, nw, r0, r1);
        chk("status_w1c", rd, 32'h0);

        // START and CLR in one write
        ahb_xfer(1'b1, 32'h00, 32'h7, 3'b010, rd, nw, r0, r1);
        @(posedge hclk); #1;
        chk("start_clr_both", {30'd0, pid_start, pid_clr}, 32'h3);

        // Error responses: unmapped read, halfword write
        ahb_xfer(1'b0, 32'h24, 32'h0, 3'b010, rd, nw, r0, r1);
        chk("unmap_err1", 32'(r0), 32'd1);
        chk("unmap_wait", 32'(nw), 32'd1);
        chk("unmap_err2", 32'(r1), 32'd1);
        chk("unmap_rdata", rd, 32'h0);
        ahb_xfer(1'b1, 32'h08, 32'h0000_FFFF, 3'b001, rd, nw, r0, r1);
        chk("hsize_err1", 32'(r0), 32'd1);
        chk("hsize_err2", {30'd0, 1'(nw), r1}, 32'h3);
        ahb_xfer(1'b0, 32'h08, 32'h0, 3'b010, rd, nw, r0, r1);
        chk("kp_unchanged", rd, 32'h0000_1234);

        // Busy core: operand write errors, START ignored
        pid_busy = 1'b1;
        ahb_xfer(1'b1, 32'h10, 32'h55, 3'b010, rd, nw, r0, r1);
        chk("busy_kd_err", {30'd0, r0, r1}, 32'h3);
        chk("busy_kd_wait", 32'(nw), 32'd1);
        ahb_xfer(1'b0, 32'h10, 32'h0, 3'b010, rd, nw, r0, r1);
        chk("kd_unchanged", rd, 32'h0);
        ahb_xfer(1'b0, 32'h04, 32'h0, 3'b010, rd, nw, r0, r1);
        chk("status_busy", rd, 32'h1);
        ahb_xfer(1'b1, 32'h00, 32'h3, 3'b010, rd, nw, r0, r1);
        chk("busy_start_okay", {30'd0, r0, r1}, 32'h0);
        chk("busy_start_wait", 32'(nw), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge hclk); #1;
            seen = seen | pid_start;
        end
        chk("busy_no_start", 32'(seen), 32'd0);
        pid_busy = 1'b0;

        // Write SP then read SP with HREADY held low one cycle
        @(posedge hclk); #1;
        bus.HSEL   = 1'b1;
        bus.HADDR  = 32'h14;
        bus.HTRANS = 2'b10;
        bus.HWRITE = 1'b1;
        bus.HSIZE  = 3'b010;
        @(posedge hclk); #1;
        bus.HWDATA = 32'h7;
        bus.HWRITE = 1'b0;
        hready_en  = 1'b0;
        @(posedge hclk); #1;
        chk("b2b_not_taken", 32'(bus.HREADYOUT), 32'd1);
        hready_en  = 1'b1;
        @(posedge hclk); #1;
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        chk("b2b_rwait", 32'(bus.HREADYOUT), 32'd0);
        @(posedge hclk); #1;
        chk("b2b_rd_ready", 32'(bus.HREADYOUT), 32'd1);
        chk("b2b_rd_data", bus.HRDATA, 32'h0000_0007);
        chk("sp_port", 32'(pid_sp), 32'h7);

        // Reset asserted while a read sits in RWAIT
        @(posedge hclk); #1;
        bus.HSEL   = 1'b1;
        bus.HADDR  = 32'h08;
        bus.HTRANS = 2'b10;
        bus.HWRITE = 1'b0;
        @(posedge hclk); #1;
        chk("pre_rst_rwait", 32'(bus.HREADYOUT), 32'd0);
        #2 hresetn = 1'b0;
        #1;
        chk("mid_rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        chk("mid_rst_hresp", 32'(bus.HRESP), 32'd0);
        chk("mid_rst_hrdata", bus.HRDATA, 32'h0);
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        @(posedge hclk); #1;
        hresetn = 1'b1;
        ahb_xfer(1'b0, 32'h08, 32'h0, 3'b010, rd, nw, r0, r1);
        chk("kp_after_rst", rd, 32'h0);
        chk("sp_port_after_rst", 32'(pid_sp), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
